// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
//   Shared defaults and operation encoding for the teaching-datapath SRAM.
//   The strobe-qualified control inputs (LDAR, RW) are collapsed into one
//   op code so the top-level registers each only test a single value.
// ---------------------------------------------------------------------------
package sram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LDAR  = 2'd1,
    OP_WRITE = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  // LDAR has priority over RW; nothing happens without a synchronised rise.
  function automatic op_e decode_op(input logic rise, input logic ldar,
                                    input logic rw);
    op_e op;
    op = OP_NONE;
    if (rise) begin
      if (ldar)     op = OP_LDAR;
      else if (rw)  op = OP_READ;
      else          op = OP_WRITE;
    end
    return op;
  endfunction

endpackage

// File: rtl/sram_strobe_sync.sv
// ---------------------------------------------------------------------------
// sram_strobe_sync
//   Brings the asynchronous 'okay' strobe into the clk domain with a 2-flop
//   synchroniser and produces a one-cycle pulse on its rising edge.
//   Ports:
//     clk   in  system clock, rising edge
//     rst   in  asynchronous reset, active-high (clears all three flops)
//     okay  in  asynchronous operation strobe
//     rise  out one-cycle pulse, high in the cycle after okay reaches s2
// ---------------------------------------------------------------------------
module sram_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic okay,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // r_s1/r_s2 form the metastability guard; r_s3 remembers the previous
  // synchronised level so a held-high strobe yields a single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= okay;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/sram.sv
// ---------------------------------------------------------------------------
// sram
//   2**ADDR_W x DATA_W static storage with an address register (AR).
//   Each synchronised rising edge of 'okay' commits exactly one operation:
//     LDAR=1        : AR <= address
//     LDAR=0, RW=0  : mem[AR] <= datain
//     LDAR=0, RW=1  : dataout <= mem[AR]
//   The operation lands on the 3rd rising clk edge after okay goes high.
//   Ports:
//     clk      in  system clock, rising edge
//     rst      in  asynchronous reset, active-high
//     dataout  out registered read data (holds last read value)
//     datain   in  write data
//     address  in  value loaded into AR
//     RW       in  0 = write, 1 = read
//     okay     in  asynchronous operation strobe (acts on its rising edge)
//     LDAR     in  1 = load AR, 0 = memory access
//   Build option:
//     SRAM_RESET_CLEAR_EN  defined   -> rst also clears every word to 0
//                          undefined -> array has no reset (maps to RAM)
// ---------------------------------------------------------------------------
module sram
  import sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] dataout,
  input  logic [DATA_W-1:0] datain,
  input  logic [ADDR_W-1:0] address,
  input  logic              RW,
  input  logic              okay,
  input  logic              LDAR
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              w_rise;
  op_e               w_op;
  logic [ADDR_W-1:0] r_ar;
  logic [DATA_W-1:0] r_dataout;
  logic [DATA_W-1:0] r_mem [DEPTH];

  sram_strobe_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .okay (okay),
    .rise (w_rise)
  );

  assign w_op = decode_op(w_rise, LDAR, RW);

  // Address register: changes only on an explicit load, never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar <= '0;
    end else if (w_op == OP_LDAR) begin
      r_ar <= address;
    end
  end

`ifdef SRAM_RESET_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_op == OP_WRITE) begin
      r_mem[r_ar] <= datain;
    end
  end
`else
  // No reset on the array so it can be mapped onto a RAM primitive.
  always_ff @(posedge clk) begin
    if (w_op == OP_WRITE) begin
      r_mem[r_ar] <= datain;
    end
  end
`endif

  // Read data register: only a read updates it, so it holds indefinitely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dataout <= '0;
    end else if (w_op == OP_READ) begin
      r_dataout <= r_mem[r_ar];
    end
  end

  assign dataout = r_dataout;

endmodule

// File: tb/tb_sram.sv
module tb_sram;

  logic       clk;
  logic       rst;
  logic [7:0] dataout;
  logic [7:0] datain;
  logic [1:0] address;
  logic       RW;
  logic       okay;
  logic       LDAR;

  sram dut (
    .clk     (clk),
    .rst     (rst),
    .dataout (dataout),
    .datain  (datain),
    .address (address),
    .RW      (RW),
    .okay    (okay),
    .LDAR    (LDAR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: plain storage of what the SRAM should hold.
  logic [7:0] m_mem [4];
  logic [1:0] m_ar;
  logic [7:0] m_dout;

  typedef struct {
    int         at_cyc;
    logic [7:0] exp;
    string      name;
  } sb_t;
  sb_t sb[$];

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: at each falling edge, compare every expectation due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      if (e.at_cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: check missed, due cycle %0d, now %0d", e.name,
                 e.at_cyc, cyc);
      end else begin
        check(e.name, dataout, e.exp);
      end
    end
  end

  task automatic push(input int at, input logic [7:0] exp, input string nm);
    sb_t e;
    e.at_cyc = at;
    e.exp    = exp;
    e.name   = nm;
    sb.push_back(e);
  endtask

  task automatic model_op(input logic ld, input logic rw,
                          input logic [1:0] a, input logic [7:0] d);
    if (ld)       m_ar = a;
    else if (!rw) m_mem[m_ar] = d;
    else          m_dout = m_mem[m_ar];
  endtask

  task automatic model_reset();
    m_dout = 8'h00;
    m_ar   = 2'd0;
`ifdef SRAM_RESET_CLEAR_EN
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
`endif
  endtask

  // One strobed operation: okay high for two cycles, controls held well past
  // the point where the action lands, then a quiet gap so the rise detector
  // is re-armed.
  task automatic strobe(input string nm, input logic ld, input logic rw,
                        input logic [1:0] a, input logic [7:0] d);
    int         n;
    logic [7:0] prev;
    LDAR    = ld;
    RW      = rw;
    address = a;
    datain  = d;
    @(posedge clk);
    #1;
    okay = 1'b1;
    n    = cyc;
    prev = m_dout;
    model_op(ld, rw, a, d);
    push(n + 2, prev,   {nm, "_early"});
    push(n + 3, m_dout, nm);
    repeat (2) @(posedge clk);
    #1 okay = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] pat [4];
    int         n;
    pat[0] = 8'h00; pat[1] = 8'h11; pat[2] = 8'h22; pat[3] = 8'h33;

    rst = 1'b1; okay = 1'b0; LDAR = 1'b0; RW = 1'b0;
    address = 2'd0; datain = 8'h00;
    for (int i = 0; i < 4; i++) m_mem[i] = 8'hxx;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // 1. reset state
    check("reset_dataout", dataout, 8'h00);
    check("reset_ar", {6'd0, dut.r_ar}, 8'h00);

    // 2. write loop
    for (int a = 0; a < 4; a++) begin
      strobe("wr_ldar", 1'b1, 1'b0, 2'(a), 8'hA5);
      strobe("wr_data", 1'b0, 1'b0, 2'(a), pat[a]);
    end

    // 3. read loop
    for (int a = 0; a < 4; a++) begin
      strobe("rd_ldar", 1'b1, 1'b1, 2'(a), 8'h5A);
      strobe("rd_data", 1'b0, 1'b1, 2'(a), 8'hC3);
    end

    // 4. held strobe: one read only; a write request presented while okay is
    //    still high must not fire.
    strobe("hold_ldar", 1'b1, 1'b1, 2'd1, 8'h00);
    strobe("hold_prime", 1'b0, 1'b1, 2'd0, 8'h00);
    strobe("hold_ldar2", 1'b1, 1'b1, 2'd2, 8'h00);
    LDAR = 1'b0; RW = 1'b1; datain = 8'h00;
    @(posedge clk);
    #1 okay = 1'b1;
    n = cyc;
    push(n + 2, m_dout, "hold_early");
    model_op(1'b0, 1'b1, 2'd0, 8'h00);
    for (int k = 3; k <= 10; k++) push(n + k, m_dout, "hold_steady");
    repeat (5) @(posedge clk);
    #1 begin RW = 1'b0; datain = 8'hEE; end
    repeat (5) @(posedge clk);
    #1 okay = 1'b0;
    repeat (4) @(posedge clk);
    strobe("hold_ldar3", 1'b1, 1'b1, 2'd1, 8'h00);
    strobe("hold_rd1", 1'b0, 1'b1, 2'd0, 8'h00);
    strobe("hold_ldar4", 1'b1, 1'b1, 2'd2, 8'h00);
    strobe("hold_rd2", 1'b0, 1'b1, 2'd0, 8'h00);

    // 5. reset during a pending write to addr 3
    strobe("rst_ldar", 1'b1, 1'b0, 2'd3, 8'h00);
    LDAR = 1'b0; RW = 1'b0; datain = 8'h99;
    @(posedge clk);
    #1 okay = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_dataout", dataout, 8'h00);
    check("rst_async_ar", {6'd0, dut.r_ar}, 8'h00);
    okay = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    strobe("rst_rd_ar0", 1'b0, 1'b1, 2'd3, 8'h00);
    strobe("rst_ldar3", 1'b1, 1'b1, 2'd3, 8'h00);
    strobe("rst_rd3", 1'b0, 1'b1, 2'd0, 8'h00);
    strobe("rst_ldar2", 1'b1, 1'b1, 2'd2, 8'h00);
    strobe("rst_rd2", 1'b0, 1'b1, 2'd0, 8'h00);

    // okay already high when rst releases: counts as one rise (load AR=1)
    LDAR = 1'b1; RW = 1'b1; address = 2'd1; datain = 8'h00;
    @(posedge clk);
    #1 begin rst = 1'b1; okay = 1'b1; end
    #1 model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    n = cyc;
    model_op(1'b1, 1'b1, 2'd1, 8'h00);
    push(n + 3, m_dout, "rel_ldar");
    repeat (2) @(posedge clk);
    #1 okay = 1'b0;
    repeat (4) @(posedge clk);
    strobe("rel_wr1", 1'b0, 1'b0, 2'd0, 8'h5C);
    strobe("rel_rd1", 1'b0, 1'b1, 2'd0, 8'h00);
    for (int a = 0; a < 4; a++) begin
      strobe("refill_ldar", 1'b1, 1'b0, 2'(a), 8'h00);
      strobe("refill_wr", 1'b0, 1'b0, 2'(a), pat[a]);
    end

    // 6. LDAR with changed datain leaves memory alone
    strobe("ld6_a", 1'b1, 1'b0, 2'd2, 8'h00);
    strobe("ld6_b", 1'b1, 1'b0, 2'd1, 8'hFF);
    strobe("ld6_rd", 1'b0, 1'b1, 2'd3, 8'h77);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      logic       ld;
      logic       rw;
      logic [1:0] a;
      logic [7:0] d;
      ld = ($urandom_range(0, 2) == 0);
      rw = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      strobe("rand_op", ld, rw, a, d);
    end
    for (int a = 0; a < 4; a++) begin
      strobe("final_ldar", 1'b1, 1'b1, 2'(a), 8'h00);
      strobe("final_rd", 1'b0, 1'b1, 2'd0, 8'h00);
    end

    repeat (4) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
